// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
// The package name matches the arithmetic tile's existing div_pkg.
package div_pkg;

   localparam int DEF_DIVIDEND_W = 8;
   localparam int DEF_DIVISOR_W  = 4;
   localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

endpackage : div_pkg

// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// The requester uses the master modport and the divider uses the slave modport.
interface seq_restoring_divider_if
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = DEF_DIVISOR_W
);

   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  busy;
   logic                  done;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );

endinterface : seq_restoring_divider_if

// File: rtl/seq_restoring_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, and keep the difference only if it did not underflow.
module div_step
   import div_pkg::*;
#(
   parameter int DIVISOR_W = DEF_DIVISOR_W
) (
   input  logic [DIVISOR_W-1:0] rem_i,
   input  logic                 bit_i,
   input  logic [DIVISOR_W-1:0] divisor_i,
   output logic [DIVISOR_W-1:0] rem_o,
   output logic                 q_o
);

   // The restored remainder is always < divisor, so only the shifted value
   // needs the extra bit; the difference wraps harmlessly into DIVISOR_W bits.
   logic [DIVISOR_W:0] shifted;

   always_comb begin
      shifted = {rem_i, bit_i};
      q_o     = (shifted >= {1'b0, divisor_i});
      rem_o   = q_o ? (shifted[DIVISOR_W-1:0] - divisor_i) : shifted[DIVISOR_W-1:0];
   end

endmodule : div_step

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
// Define SEQ_RESTORING_DIVIDER_DIV_ZERO_EN to short-circuit a zero divisor straight to DONE.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
   input logic                    clk,
   input logic                    rst,
   seq_restoring_divider_if.slave bus
);

   localparam int CNT_W = $clog2(DIVIDEND_W);

   state_e                state_q,     state_d;
   logic [CNT_W-1:0]      cnt_q,       cnt_d;
   logic [DIVISOR_W-1:0]  rem_q,       rem_d;
   logic [DIVIDEND_W-1:0] q_acc_q,     q_acc_d;
   logic [DIVIDEND_W-1:0] dividend_q,  dividend_d;
   logic [DIVISOR_W-1:0]  divisor_q,   divisor_d;
   logic [DIVIDEND_W-1:0] quotient_q,  quotient_d;
   logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
`ifdef SEQ_RESTORING_DIVIDER_DIV_ZERO_EN
   logic                  div_zero_q,  div_zero_d;
`endif

   logic [DIVISOR_W-1:0]  step_rem;
   logic                  step_q;
   logic                  accept;

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .rem_i     (rem_q),
      .bit_i     (dividend_q[cnt_q]),
      .divisor_i (divisor_q),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path
      // through the case statement leaves it unassigned (which would infer a latch).
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      q_acc_d     = q_acc_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
`ifdef SEQ_RESTORING_DIVIDER_DIV_ZERO_EN
      div_zero_d  = div_zero_q;
`endif
      accept      = 1'b0;

      case (state_q)
         IDLE: accept = bus.start;
         CALC: begin
            rem_d   = step_rem;
            q_acc_d = {q_acc_q[DIVIDEND_W-2:0], step_q};
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d     = DONE;
               quotient_d  = {q_acc_q[DIVIDEND_W-2:0], step_q};
               remainder_d = step_rem;
`ifdef SEQ_RESTORING_DIVIDER_DIV_ZERO_EN
               div_zero_d  = 1'b0;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
            accept  = bus.start;
         end
         default: state_d = IDLE;
      endcase

      // A start in IDLE or DONE behaves identically, enabling back-to-back operations.
      if (accept) begin
         dividend_d = bus.dividend;
         divisor_d  = bus.divisor;
         rem_d      = '0;
         q_acc_d    = '0;
         cnt_d      = CNT_W'(DIVIDEND_W - 1);
         state_d    = CALC;
`ifdef SEQ_RESTORING_DIVIDER_DIV_ZERO_EN
         if (bus.divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend[DIVISOR_W-1:0];
            div_zero_d  = 1'b1;
         end
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         q_acc_q     <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
`ifdef SEQ_RESTORING_DIVIDER_DIV_ZERO_EN
         div_zero_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         q_acc_q     <= q_acc_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
`ifdef SEQ_RESTORING_DIVIDER_DIV_ZERO_EN
         div_zero_q  <= div_zero_d;
`endif
      end
   end

   // NOTE: operand registers are deliberately not reset; they are always
   // written on an accepted start before anything reads them.
   always_ff @(posedge clk) begin
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
   end

   assign bus.busy      = (state_q == CALC);
   assign bus.done      = (state_q == DONE);
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
`ifdef SEQ_RESTORING_DIVIDER_DIV_ZERO_EN
   assign bus.div_zero  = div_zero_q;
`else
   assign bus.div_zero  = 1'b0;
`endif

endmodule : seq_restoring_divider

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider with hand-computed results.
// Expectations follow SEQ_RESTORING_DIVIDER_DIV_ZERO_EN when it is defined.
module tb_seq_restoring_divider;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   seq_restoring_divider_if bus ();

   seq_restoring_divider dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until done (bounded), returning cycles since the start edge and busy cycles seen.
   task automatic wait_done(output int lat, output int busy_cnt);
      int overlap = 0;
      lat      = 1;
      busy_cnt = 0;
      while (bus.done !== 1'b1 && lat < 20) begin
         if (bus.busy === 1'b1) busy_cnt++;
         tick();
         lat++;
      end
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1;
      check("busy_done_overlap", overlap, 0);
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input int exp_q, input int exp_r, input int exp_dz,
                         input int exp_lat, input int exp_busy);
      int lat;
      int bc;
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      tick();
      bus.start    = 1'b0;
      bus.dividend = ~a;
      bus.divisor  = ~b;
      wait_done(lat, bc);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, bc, exp_busy);
      check({tag, "_quotient"}, bus.quotient, exp_q);
      check({tag, "_remainder"}, bus.remainder, exp_r);
      check({tag, "_div_zero"}, bus.div_zero, exp_dz);
      tick();
      check({tag, "_done_one_cycle"}, bus.done, 0);
      check({tag, "_quotient_hold"}, bus.quotient, exp_q);
   endtask

   initial begin
      int lat;
      int bc;
      int seen_done;

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      tick();
      tick();
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_quotient", bus.quotient, 0);
      check("reset_remainder", bus.remainder, 0);
      check("reset_div_zero", bus.div_zero, 0);
      rst = 1'b0;
      tick();

      run_op("d200_7",   8'd200, 4'd7,  28,  4, 0, 9, 8);
      run_op("d225_15",  8'd225, 4'd15, 15,  0, 0, 9, 8);
      run_op("d255_1",   8'd255, 4'd1,  255, 0, 0, 9, 8);
      run_op("d5_9",     8'd5,   4'd9,  0,   5, 0, 9, 8);
`ifdef SEQ_RESTORING_DIVIDER_DIV_ZERO_EN
      run_op("dA7_0",    8'hA7,  4'd0,  255, 7, 1, 1, 0);
`else
      run_op("dA7_0",    8'hA7,  4'd0,  255, 7, 0, 9, 8);
`endif

      // Reset during the 4th CALC cycle of 200 / 7 aborts without a done pulse.
      bus.start    = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 4'd7;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      check("abort_busy_before_rst", bus.busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_quotient", bus.quotient, 0);
      check("abort_remainder", bus.remainder, 0);
      check("abort_div_zero", bus.div_zero, 0);
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done === 1'b1) seen_done = 1;
      end
      check("abort_no_done", seen_done, 0);
      run_op("d100_3", 8'd100, 4'd3, 33, 1, 0, 9, 8);

      // start held high through CALC and DONE: CALC ignores it, DONE accepts 96 / 12.
      bus.start    = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 4'd7;
      tick();
      bus.dividend = 8'd96;
      bus.divisor  = 4'd12;
      wait_done(lat, bc);
      check("b2b_first_latency", lat, 9);
      check("b2b_first_busy_cycles", bc, 8);
      check("b2b_first_quotient", bus.quotient, 28);
      check("b2b_first_remainder", bus.remainder, 4);
      tick();
      bus.start = 1'b0;
      check("b2b_second_busy", bus.busy, 1);
      check("b2b_second_done_low", bus.done, 0);
      wait_done(lat, bc);
      check("b2b_second_latency", lat, 9);
      check("b2b_second_busy_cycles", bc, 8);
      check("b2b_second_quotient", bus.quotient, 8);
      check("b2b_second_remainder", bus.remainder, 0);
      tick();
      check("b2b_idle_done", bus.done, 0);
      check("b2b_idle_busy", bus.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_seq_restoring_divider

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Multi-cycle unsigned restoring divider: the inverse of the team's 4x4 array multiplier, recovering an 8-bit quotient and 4-bit remainder from an 8-bit dividend and a 4-bit divisor. It resolves one quotient bit per clock behind a start/busy/done handshake. It sits beside the multiplier in the arithmetic tile and shares its operand widths, so a product can be divided back by either factor.

## Interface
- DIVIDEND_W, 8, dividend and quotient width
- DIVISOR_W, 4, divisor and remainder width
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  DIVIDEND_W  unsigned dividend, captured on accepted start
- divisor  input  DIVISOR_W  unsigned divisor, captured on accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; results valid
- quotient  output  DIVIDEND_W  registered quotient
- remainder  output  DIVISOR_W  registered remainder
- div_zero  output  1  divisor was zero (valid with done)

## Operation
- States: IDLE, CALC, DONE.
- IDLE: start=1 captures operands, clears partial remainder R (DIVISOR_W+1 bits), sets bit counter to DIVIDEND_W-1, goes to CALC. start=0 stays in IDLE.
- CALC, per cycle, MSB first: R' = {R[DIVISOR_W-1:0], dividend[i]}. If R' >= divisor then R = R' - divisor and q[i]=1, else R = R' and q[i]=0. After i=0, load quotient/remainder registers, go to DONE.
- DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back), otherwise go to IDLE.
- start while in CALC is ignored; operand changes after capture have no effect.
- quotient, remainder, div_zero hold their values until the next completion or until reset.
- All arithmetic is unsigned. The remainder is R[DIVISOR_W-1:0] and is always < divisor when divisor != 0.
- Divisor zero without the macro: the algorithm runs unchanged and yields quotient all-ones and remainder = dividend[DIVISOR_W-1:0]; div_zero stays 0.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_zero=0, state=IDLE.
- Accepting start at edge N: busy=1 in the cycles following edges N..N+7, which is DIVIDEND_W cycles.
- The last iteration occurs at edge N+8. In the cycle after it, done=1, busy=0, and results are valid.
- busy and done are never high together.
- rst asserted at any edge, including mid-CALC, forces reset values at that edge. No done is issued for the aborted operation.

## Configuration
- Macro: SEQ_RESTORING_DIVIDER_DIV_ZERO_EN.
- Defined: a start with divisor==0 skips CALC and goes straight to DONE. done pulses in the cycle after edge N, with quotient all-ones, remainder = dividend[DIVISOR_W-1:0] and div_zero=1. busy never rises.
- Undefined: the div_zero port exists but is tied to 0, and a zero divisor takes the full DIVIDEND_W-cycle path.

## Structure
- Package div_pkg holds the state enum (IDLE, CALC, DONE), the default width constants, and the counter width ($clog2(DIVIDEND_W)).
- Sub-module div_step: purely combinational single restoring step. Inputs are partial remainder, incoming dividend bit and divisor. Outputs are the next partial remainder and the quotient bit.
- The top level holds the FSM, counter and registers.

## Test plan
- 200 / 7 -> done 9 cycles after the start edge; quotient=28, remainder=4, div_zero=0; busy high exactly 8 cycles.
- 225 / 15 -> quotient=15, remainder=0. 255 / 1 -> quotient=255, remainder=0. 5 / 9 -> quotient=0, remainder=5.
- 0xA7 / 0 with macro defined -> done in the cycle after the start edge; quotient=0xFF, remainder=0x7, div_zero=1, busy never high. Without the macro -> same quotient/remainder after 8 busy cycles, div_zero=0.
- rst pulsed at the 4th CALC cycle of 200 / 7 -> all outputs 0 at the next cycle; no done pulse; a following start of 100 / 3 gives quotient=33, remainder=1.
- start held high through DONE of 200 / 7 with new operands 96 / 12 -> second operation begins immediately; quotient=8, remainder=0; starts issued during CALC are ignored.
